snoop_resp_lv1: RTL

//  Bus-side snoop responder for one L1 cache. It accepts a bus transaction broadcast by another core
//  (BusRd, BusRdX or Invalidate) and looks the address up in the local tag/MESI array.
//  It asserts shared, flushes a modified line to the bus, writes the new MESI state back and signals completion.
//  It sits between the shared bus and the L1 array, one instance per core.

---
 rtl/snoop_resp_lv1_pkg.sv | 68 ++++++
 rtl/snoop_resp_lv1.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/snoop_resp_lv1_pkg.sv
// Shared MESI/snoop types for the L1 snoop responder: state encodings, bus op,
// FSM state and the RESP-state decode of (hit, MESI, op).
package mesi_pkg_lv1;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_RDX  = 2'b10,
        OP_INV  = 2'b11
    } snoop_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_RESP   = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } snoop_state_e;

    typedef struct packed {
        logic  wr_en;
        mesi_e wr_val;
        logic  err;
        logic  flush;
    } resp_dec_t;

    // An upgrade against an E or M copy is illegal: the line is dropped to I and flagged.
    function automatic resp_dec_t resp_decode(input logic hit, input mesi_e mesi, input snoop_op_e op);
        resp_dec_t dec;
        dec = '0;
        if (hit) begin
            case (mesi)
                MESI_S: begin
                    dec.wr_en  = 1'b1;
                    dec.wr_val = (op == OP_RD) ? MESI_S : MESI_I;
                end
                MESI_E: begin
                    dec.wr_en  = 1'b1;
                    dec.wr_val = (op == OP_RD) ? MESI_S : MESI_I;
                    dec.err    = (op == OP_INV);
                end
                MESI_M: begin
                    if (op == OP_INV) begin
                        dec.wr_en  = 1'b1;
                        dec.wr_val = MESI_I;
                        dec.err    = 1'b1;
                    end else begin
                        dec.flush = 1'b1;
                    end
                end
                default: begin
                    dec.wr_en = 1'b0;
                end
            endcase
        end else begin
            dec.wr_en = 1'b0;
        end
        return dec;
    endfunction

endpackage

// File: rtl/snoop_resp_lv1.sv
// Bus-side snoop responder for one L1: looks up a remote BusRd/BusRdX/Invalidate,
// flushes modified data, writes back the new MESI state and signals completion.
module snoop_resp_lv1
    import mesi_pkg_lv1::*;
#(
    parameter int MESI_WID  = 2,
    parameter int ADDR_WID  = 32,
    parameter int DATA_WID  = 32,
    parameter int INDEX_WID = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 snoop_req,
    input  logic                 bus_rd,
    input  logic                 bus_rdx,
    input  logic                 invalidate,
    input  logic [ADDR_WID-1:0]  bus_addr,
    output logic                 tag_rd_en,
    output logic [INDEX_WID-1:0] tag_index,
    output logic [ADDR_WID-1:0]  tag_addr,
    input  logic                 arr_hit,
    input  logic [MESI_WID-1:0]  arr_mesi,
    input  logic [DATA_WID-1:0]  arr_data,
    output logic                 mesi_wr_en,
    output logic [MESI_WID-1:0]  mesi_wr_val,
    output logic                 shared,
    output logic                 flush_valid,
    output logic [DATA_WID-1:0]  flush_data,
    input  logic                 flush_ready,
    output logic                 snoop_done,
    output logic                 proto_err
);

    snoop_state_e          state_r, state_n_s;
    snoop_op_e             op_r, op_sel_s;
    logic [ADDR_WID-1:0]   addr_r, tag_addr_s;
    logic                  hit_r, shared_r;
    mesi_e                 mesi_r, arr_mesi_s, wr_val_s;
    logic [DATA_WID-1:0]   data_r;
    resp_dec_t             dec_s;
    logic [1:0]            op_cnt_s;
    logic                  op_any_s, launch_s, accept_s;
    logic                  rd_en_s, wr_en_s, err_s, fv_s, done_s;

    assign op_cnt_s   = {1'b0, bus_rd} + {1'b0, bus_rdx} + {1'b0, invalidate};
    assign op_any_s   = (op_cnt_s != 2'd0);
    assign op_sel_s   = bus_rdx ? OP_RDX : (bus_rd ? OP_RD : (invalidate ? OP_INV : OP_NONE));
    assign arr_mesi_s = mesi_e'(arr_mesi);
    assign dec_s      = resp_decode(hit_r, mesi_r, op_r);

    // Next-state and strobe decode; strobes default low and are raised per state.
    always_comb begin
        state_n_s = state_r;
        launch_s  = 1'b0;
        accept_s  = 1'b0;
        rd_en_s   = 1'b0;
        wr_en_s   = 1'b0;
        wr_val_s  = MESI_I;
        err_s     = 1'b0;
        fv_s      = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (snoop_req && op_any_s) begin
                    launch_s  = 1'b1;
                    rd_en_s   = 1'b1;
                    err_s     = (op_cnt_s > 2'd1);
                    state_n_s = ST_LOOKUP;
                end else begin
                    err_s     = snoop_req;
                    state_n_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                state_n_s = ST_RESP;
            end
            ST_RESP: begin
                if (dec_s.flush) begin
                    state_n_s = ST_FLUSH;
                end else begin
                    wr_en_s   = dec_s.wr_en;
                    wr_val_s  = dec_s.wr_val;
                    err_s     = dec_s.err;
                    state_n_s = ST_DONE;
                end
            end
            ST_FLUSH: begin
                fv_s = 1'b1;
                if (flush_ready) begin
                    accept_s  = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_val_s  = (op_r == OP_RD) ? MESI_S : MESI_I;
                    state_n_s = ST_DONE;
                end else begin
                    state_n_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                done_s    = 1'b1;
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Request latch, lookup capture and the shared flag held until the transaction completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r     <= OP_NONE;
            addr_r   <= '0;
            hit_r    <= 1'b0;
            mesi_r   <= MESI_I;
            data_r   <= '0;
            shared_r <= 1'b0;
        end else begin
            if (launch_s) begin
                op_r   <= op_sel_s;
                addr_r <= bus_addr;
            end
            if (state_r == ST_LOOKUP) begin
                hit_r    <= arr_hit;
                mesi_r   <= arr_mesi_s;
                data_r   <= arr_data;
                shared_r <= arr_hit && (op_r == OP_RD) &&
                            ((arr_mesi_s == MESI_S) || (arr_mesi_s == MESI_E));
            end else if (accept_s) begin
                shared_r <= (op_r == OP_RD);
            end else if (state_r == ST_DONE) begin
                shared_r <= 1'b0;
            end
        end
    end

    // The lookup address comes straight from the bus in the accept cycle, from the latch afterwards.
    assign tag_addr_s  = launch_s ? bus_addr : addr_r;
    assign tag_addr    = tag_addr_s;
    assign tag_index   = tag_addr_s[INDEX_WID+1:2];
    assign tag_rd_en   = rd_en_s;
    assign mesi_wr_en  = wr_en_s;
    assign mesi_wr_val = MESI_WID'(wr_val_s);
    assign shared      = shared_r | (accept_s && (op_r == OP_RD));
    assign flush_valid = fv_s;
    assign flush_data  = fv_s ? data_r : '0;
    assign snoop_done  = done_s;
    assign proto_err   = err_s;

endmodule
